seq_analyzer_param: RTL and testbench
=====================================

Name: seq_analyzer_param

Overview:
- Parametrised successor of the fixed 16-symbol nibble sequence analyser. It detects a runtime-programmable pattern of SEQ_LEN symbols, each SYM_W bits wide, in a stream of input symbols qualified by a clock enable.
- Progress is tracked as the longest received suffix that equals a pattern prefix, so a partial mismatch falls back correctly instead of dropping to zero.
- Adds an overlap/non-overlap mode, a one-cycle match pulse, and a saturating match counter.
- Sits between the symbol source and the indication/LED logic, in the same place as the fixed analyser.

Parameters:
- SYM_W, 4: symbol width in bits.
- SEQ_LEN, 16: pattern length in symbols (>=2).
- CNT_W, 8: match counter width.
- PAT_INIT, 64'h297A23C980A24147: reset pattern. Symbol i is at bits [i*SYM_W +: SYM_W]; symbol 0 is expected first. The default sequence is 7,4,1,4,2,A,0,8,9,C,3,2,A,7,9,2.

Ports:
- CLK, in, 1: clock, rising edge.
- RST, in, 1: synchronous active-high reset.
- CE, in, 1: input symbol valid/enable.
- DAT_I, in, SYM_W: input symbol.
- CLR, in, 1: synchronous clear of history and progress.
- OVERLAP, in, 1: 1 = overlapping matches allowed; 0 = history flushed after each match.
- PAT_WE, in, 1: pattern write strobe.
- PAT_ADDR, in, $clog2(SEQ_LEN): pattern symbol index.
- PAT_DAT, in, SYM_W: pattern symbol data.
- NOM, out, SEQ_LEN: thermometer progress; bits [PROG-1:0] set.
- PROG, out, $clog2(SEQ_LEN+1): progress count, 0..SEQ_LEN.
- MATCH, out, 1: one-cycle pulse on a full match.
- MATCH_CNT, out, CNT_W: saturating count of matches.

Behaviour:
- One clock domain (CLK); reset is synchronous and active-high (RST). All state changes on the rising CLK edge. All outputs are registered.
- Reset values: NOM=0, PROG=0, MATCH=0, MATCH_CNT=0, history empty (HCNT=0), pattern=PAT_INIT.
- Internal state:
  - History shift register of the last SEQ_LEN accepted symbols.
  - HCNT: number of valid history symbols, saturating at SEQ_LEN.
  - Pattern RAM of SEQ_LEN x SYM_W registers.
- Priority per edge: RST > PAT_WE > CLR > CE.
- PAT_WE=1:
  - If PAT_ADDR < SEQ_LEN, the pattern symbol at that index is written. Out-of-range addresses are ignored (no write).
  - In both cases history, HCNT, PROG and NOM are cleared and MATCH=0. MATCH_CNT is held.
  - A symbol presented with CE in the same cycle is dropped.
- CLR=1 (no PAT_WE): history, HCNT, PROG and NOM cleared; MATCH=0; MATCH_CNT held; the CE symbol is dropped.
- CE=1 (no RST/PAT_WE/CLR):
  - DAT_I is appended to history; HCNT increments, saturating.
  - New PROG = largest k, 0<=k<=min(HCNT_new, SEQ_LEN), such that the last k accepted symbols equal pattern symbols 0..k-1 in order.
  - NOM = (1<<PROG)-1.
  - Result is visible the cycle after the accepting edge; latency is 1.
- Full match (new PROG == SEQ_LEN):
  - MATCH=1 for exactly that one registered cycle.
  - MATCH_CNT increments, holding at 2^CNT_W-1 once reached.
  - OVERLAP=1: history is kept, so the next PROG is computed against the full history and overlapping occurrences are counted.
  - OVERLAP=0: on the match edge, history and HCNT are cleared. NOM/PROG still show SEQ_LEN (all ones) for that cycle, and the next accepted symbol starts from empty history.
- CE=0: all state held; MATCH forced to 0 on that edge.
- OVERLAP is sampled only on the match edge; changing it mid-sequence has no other effect.
- Symbol accepted in the cycle immediately after a match: it is evaluated normally, using the post-match history per OVERLAP.
- Comparison is purely combinational from the history and pattern registers into the PROG register. For the default parameters this is SEQ_LEN*(SEQ_LEN+1)/2 symbol compares; no multicycle paths.

Test Plan:
- Defaults; RST; feed 7,4,1,4,2,A,0,8,9,C,3,2,A,7,9,2 with CE=1 -> NOM steps 0x0001, 0x0003 ... 0xFFFF; MATCH=1 for one cycle after the 16th symbol; MATCH_CNT=1.
- Defaults; feed 7,4,1,4,7,4 -> PROG 1,2,3,4,1,2 (fallback on 7, not 0); feed 7,7 -> PROG 1,1.
- SEQ_LEN=4; program pattern A,B,A,B via PAT_WE; stream A,B,A,B,A,B:
  - OVERLAP=1 -> MATCH after symbols 4 and 6, MATCH_CNT=2, final PROG=4.
  - OVERLAP=0 -> one MATCH, final PROG=2.
- CE toggled low between each defaults-sequence symbol, with DAT_I=F while CE=0 -> identical NOM trace; no change while CE=0.
- Mid-sequence (PROG=5) cases:
  - Assert RST -> next cycle NOM=0, MATCH_CNT=0, pattern back to PAT_INIT.
  - Separately, assert CLR together with CE -> PROG=0, symbol dropped, MATCH_CNT held.
  - Separately, PAT_WE with PAT_ADDR=SEQ_LEN -> no pattern change, progress cleared.
- CNT_W=2, OVERLAP=1, pattern of four zeros (SEQ_LEN=4), 10 zeros streamed -> matches on symbols 4..10; MATCH_CNT saturates at 3 with MATCH still pulsing each symbol.

Source files
------------

// File: rtl/seq_analyzer_param.sv
// seq_analyzer_param: detects a programmable SEQ_LEN-symbol pattern in a CE-qualified symbol stream
// Ports: CLK/RST (sync, active-high); CE/DAT_I symbol in; CLR clears progress;
//   OVERLAP selects overlapping matches; PAT_WE/PAT_ADDR/PAT_DAT program the pattern;
//   NOM thermometer and PROG count of progress; MATCH one-cycle pulse; MATCH_CNT saturating count.
module seq_analyzer_param #(
    parameter int SYM_W = 4,
    parameter int SEQ_LEN = 16,
    parameter int CNT_W = 8,
    parameter logic [SEQ_LEN*SYM_W-1:0] PAT_INIT = 64'h297A23C980A24147
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         CE,
    input  logic [SYM_W-1:0]             DAT_I,
    input  logic                         CLR,
    input  logic                         OVERLAP,
    input  logic                         PAT_WE,
    input  logic [$clog2(SEQ_LEN)-1:0]   PAT_ADDR,
    input  logic [SYM_W-1:0]             PAT_DAT,
    output logic [SEQ_LEN-1:0]           NOM,
    output logic [$clog2(SEQ_LEN+1)-1:0] PROG,
    output logic                         MATCH,
    output logic [CNT_W-1:0]             MATCH_CNT
);
    localparam int PW = $clog2(SEQ_LEN+1);
    localparam logic [PW-1:0] FULL = PW'(SEQ_LEN);
    // hist[0] is the most recently accepted symbol
    logic [SYM_W-1:0] hist [SEQ_LEN];
    logic [SYM_W-1:0] hn [SEQ_LEN];
    logic [SYM_W-1:0] pat [SEQ_LEN];
    logic [PW-1:0] hcnt, hcnt_n, prog_n;
    logic [SEQ_LEN-1:0] nom_n;
    logic [SEQ_LEN:1] ok;
    logic full;
    always_comb begin
        hn[0] = DAT_I;
        for (int i = 1; i < SEQ_LEN; i++) hn[i] = hist[i-1];
        hcnt_n = (hcnt == FULL) ? hcnt : hcnt + 1'b1;
    end
    // ok[k]: the newest k symbols equal pattern prefix 0..k-1 and are all valid history
    for (genvar k = 1; k <= SEQ_LEN; k++) begin : g_k
        logic [k-1:0] eq;
        for (genvar j = 0; j < k; j++) begin : g_j
            assign eq[j] = hn[k-1-j] == pat[j];
        end
        assign ok[k] = &eq && (hcnt_n >= PW'(k));
    end
    assign full = ok[SEQ_LEN];
    always_comb begin
        prog_n = '0;
        for (int k = 1; k <= SEQ_LEN; k++) prog_n = ok[k] ? PW'(k) : prog_n;
        for (int i = 0; i < SEQ_LEN; i++) nom_n[i] = PW'(i) < prog_n;
    end
    // history contents beyond hcnt are never compared, so clearing hcnt empties it
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < SEQ_LEN; i++) pat[i] <= PAT_INIT[i*SYM_W +: SYM_W];
            hcnt <= '0;
            PROG <= '0;
            NOM <= '0;
            MATCH <= 1'b0;
            MATCH_CNT <= '0;
        end else if (PAT_WE || CLR) begin
            if (PAT_WE && int'(PAT_ADDR) < SEQ_LEN) pat[PAT_ADDR] <= PAT_DAT;
            hcnt <= '0;
            PROG <= '0;
            NOM <= '0;
            MATCH <= 1'b0;
        end else if (CE) begin
            hist <= hn;
            hcnt <= (full && !OVERLAP) ? '0 : hcnt_n;
            PROG <= prog_n;
            NOM <= nom_n;
            MATCH <= full;
            MATCH_CNT <= MATCH_CNT + CNT_W'(full && !(&MATCH_CNT));
        end else begin
            MATCH <= 1'b0;
        end
    end
endmodule

// File: tb/tb_seq_analyzer_param.sv
// tb_seq_analyzer_param: scoreboard bench for two analyser configurations (16-symbol default, 5-symbol/2-bit counter)
module tb_seq_analyzer_param;
    localparam logic [63:0] PINIT = 64'h297A23C980A24147;
    localparam int LEN [2] = '{16, 5};
    localparam int CMAX [2] = '{255, 3};
    logic clk = 0;
    always #5 clk = ~clk;
    logic a_rst, a_ce, a_clr, a_ov, a_we, a_match;
    logic [3:0] a_d, a_addr, a_pd;
    logic [15:0] a_nom;
    logic [4:0] a_prog;
    logic [7:0] a_cnt;
    logic b_rst, b_ce, b_clr, b_ov, b_we, b_match;
    logic [3:0] b_d, b_pd;
    logic [2:0] b_addr;
    logic [4:0] b_nom;
    logic [2:0] b_prog;
    logic [1:0] b_cnt;
    seq_analyzer_param dut_a (
        .CLK(clk), .RST(a_rst), .CE(a_ce), .DAT_I(a_d), .CLR(a_clr), .OVERLAP(a_ov),
        .PAT_WE(a_we), .PAT_ADDR(a_addr), .PAT_DAT(a_pd),
        .NOM(a_nom), .PROG(a_prog), .MATCH(a_match), .MATCH_CNT(a_cnt)
    );
    seq_analyzer_param #(.SEQ_LEN(5), .CNT_W(2), .PAT_INIT(20'h24147)) dut_b (
        .CLK(clk), .RST(b_rst), .CE(b_ce), .DAT_I(b_d), .CLR(b_clr), .OVERLAP(b_ov),
        .PAT_WE(b_we), .PAT_ADDR(b_addr), .PAT_DAT(b_pd),
        .NOM(b_nom), .PROG(b_prog), .MATCH(b_match), .MATCH_CNT(b_cnt)
    );
    // reference model: per-configuration history list (oldest first), pattern and counters
    int hist [2][16];
    int pat [2][16];
    int hlen [2];
    int mprog [2];
    int mcnt [2];
    logic [31:0] qa [$];
    logic [31:0] qb [$];
    int errors = 0;
    int checks = 0;
    int seq16 [16] = '{7, 4, 1, 4, 2, 10, 0, 8, 9, 12, 3, 2, 10, 7, 9, 2};
    task automatic model(input int id, input bit rst, we, input int addr, pd,
                         input bit clr, ce, input int d, input bit ov);
        int l;
        bit m;
        logic [31:0] e;
        l = LEN[id];
        m = 0;
        if (rst) begin
            for (int i = 0; i < l; i++) pat[id][i] = int'((PINIT >> (4*i)) & 64'hF);
            hlen[id] = 0; mprog[id] = 0; mcnt[id] = 0;
        end else if (we || clr) begin
            if (we && addr < l) pat[id][addr] = pd;
            hlen[id] = 0; mprog[id] = 0;
        end else if (ce) begin
            if (hlen[id] < l) begin
                hist[id][hlen[id]] = d;
                hlen[id]++;
            end else begin
                for (int j = 0; j < l - 1; j++) hist[id][j] = hist[id][j+1];
                hist[id][l-1] = d;
            end
            mprog[id] = 0;
            for (int k = 1; k <= hlen[id]; k++) begin
                bit same = 1;
                for (int j = 0; j < k; j++)
                    if (hist[id][hlen[id]-k+j] != pat[id][j]) same = 0;
                if (same) mprog[id] = k;
            end
            m = mprog[id] == l;
            if (m) begin
                if (mcnt[id] < CMAX[id]) mcnt[id]++;
                if (!ov) hlen[id] = 0;
            end
        end
        e = {2'b0, 8'(mcnt[id]), m, 5'(mprog[id]), 16'((32'd1 << mprog[id]) - 1)};
        if (id == 0) qa.push_back(e); else qb.push_back(e);
    endtask
    task automatic drive(input int id, input bit rst, we, input int addr, pd,
                         input bit clr, ce, input int d, input bit ov);
        @(negedge clk);
        {a_rst, a_we, a_clr, a_ce, a_ov, a_addr, a_pd, a_d} = '0;
        {b_rst, b_we, b_clr, b_ce, b_ov, b_addr, b_pd, b_d} = '0;
        if (id == 0) begin
            a_rst = rst; a_we = we; a_addr = 4'(addr); a_pd = 4'(pd);
            a_clr = clr; a_ce = ce; a_d = 4'(d); a_ov = ov;
        end else begin
            b_rst = rst; b_we = we; b_addr = 3'(addr); b_pd = 4'(pd);
            b_clr = clr; b_ce = ce; b_d = 4'(d); b_ov = ov;
        end
        model(id, rst, we, addr, pd, clr, ce, d, ov);
    endtask
    task automatic sym(input int id, input int d, input bit ov);
        drive(id, 0, 0, 0, 0, 0, 1, d, ov);
    endtask
    task automatic wpat(input int id, input int addr, input int pd);
        drive(id, 0, 1, addr, pd, 0, 0, 0, 0);
    endtask
    task automatic rnd(input int id, input int n);
        for (int i = 0; i < n; i++) begin
            int r, d;
            r = $urandom_range(0, 199);
            d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : pat[id][mprog[id] % LEN[id]];
            drive(id, r == 0, r >= 1 && r < 4, $urandom_range(0, id == 0 ? 15 : 7),
                  $urandom_range(0, 15), r >= 4 && r < 8, $urandom_range(0, 4) != 0, d,
                  1'($urandom_range(0, 1)));
        end
    endtask
    // monitor: every cycle with a pending expectation, compare the registered outputs
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() != 0) begin
                logic [31:0] e, g;
                e = qa.pop_front();
                g = {2'b0, a_cnt, a_match, a_prog, a_nom};
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL cfg16 t=%0t: got cnt=%0d match=%0d prog=%0d nom=%h, want cnt=%0d match=%0d prog=%0d nom=%h",
                             $time, g[29:22], g[21], g[20:16], g[15:0], e[29:22], e[21], e[20:16], e[15:0]);
                end
            end
            if (qb.size() != 0) begin
                logic [31:0] e, g;
                e = qb.pop_front();
                g = {2'b0, 8'(b_cnt), b_match, 5'(b_prog), 16'(b_nom)};
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL cfg5 t=%0t: got cnt=%0d match=%0d prog=%0d nom=%h, want cnt=%0d match=%0d prog=%0d nom=%h",
                             $time, g[29:22], g[21], g[20:16], g[15:0], e[29:22], e[21], e[20:16], e[15:0]);
                end
            end
        end
    end
    initial begin
        {a_rst, a_we, a_clr, a_ce, a_ov, a_addr, a_pd, a_d} = '0;
        {b_rst, b_we, b_clr, b_ce, b_ov, b_addr, b_pd, b_d} = '0;
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) sym(0, seq16[i], 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
        foreach (seq16[i]) if (i < 6) sym(0, i < 4 ? seq16[i] : seq16[i-4], 1);
        sym(0, 7, 1);
        sym(0, 7, 1);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            sym(0, seq16[i], 0);
            drive(0, 0, 0, 0, 0, 0, 0, 15, 0);
        end
        wpat(0, 0, 3);
        sym(0, 3, 1);
        for (int i = 1; i < 5; i++) sym(0, seq16[i], 1);
        drive(0, 1, 0, 0, 0, 0, 1, seq16[5], 1);
        for (int i = 0; i < 16; i++) sym(0, seq16[i], 1);
        for (int i = 0; i < 5; i++) sym(0, seq16[i], 1);
        drive(0, 0, 0, 0, 0, 1, 1, seq16[5], 1);
        sym(0, seq16[5], 1);
        for (int i = 0; i < 16; i++) wpat(0, i, 0);
        for (int i = 0; i < 300; i++) sym(0, 0, 1);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        rnd(0, 800);
        for (int i = 0; i < 5; i++) wpat(1, i, (i % 2 == 0) ? 10 : 11);
        for (int i = 0; i < 7; i++) sym(1, (i % 2 == 0) ? 10 : 11, 1);
        drive(1, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) sym(1, (i % 2 == 0) ? 10 : 11, 0);
        for (int i = 0; i < 3; i++) sym(1, (i % 2 == 0) ? 10 : 11, 1);
        wpat(1, 5, 0);
        wpat(1, 7, 3);
        for (int i = 0; i < 5; i++) sym(1, (i % 2 == 0) ? 10 : 11, 1);
        for (int i = 0; i < 5; i++) wpat(1, i, 0);
        for (int i = 0; i < 10; i++) sym(1, 0, 1);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        rnd(1, 800);
        @(negedge clk);
        {a_rst, a_we, a_clr, a_ce, a_ov, a_addr, a_pd, a_d} = '0;
        {b_rst, b_we, b_clr, b_ce, b_ov, b_addr, b_pd, b_d} = '0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (qa.size() + qb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", qa.size() + qb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
